// File: rtl/pmem_arb.sv
// pmem_arb: two-master arbiter in front of the single physical-memory port.
//   Master 0 is the pager (CPU path) and master 1 is a secondary requester
//   (console/DMA). One master owns the pmem bus at a time. Fairness comes from
//   round-robin on the last-served pointer. m0_lock keeps the bus with the pager
//   across PTE read / data / PTE write sequences. A bus timeout finishes a stuck
//   op with a synthesized nxm.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   m0_* / m1_*           master request (addr, write data, read, write) and
//                         completion (read data, read/write ack, nxm);
//                         m0_lock keeps the m0 grant after its ack
//   pmem_*                memory request out, completion and read data in
//   grant                 one-hot owner {m0,m1}, 00 when idle
//   timeout               one-cycle pulse on a forced completion
module pmem_arb #(
    parameter int AW      = 22,
    parameter int DW      = 36,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_write_data,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic          m0_lock,
    output logic [DW-1:0] m0_read_data,
    output logic          m0_read_ack,
    output logic          m0_write_ack,
    output logic          m0_nxm,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_write_data,
    input  logic          m1_read,
    input  logic          m1_write,
    output logic [DW-1:0] m1_read_data,
    output logic          m1_read_ack,
    output logic          m1_write_ack,
    output logic          m1_nxm,
    output logic [AW-1:0] pmem_addr,
    output logic [DW-1:0] pmem_write_data,
    output logic          pmem_read,
    output logic          pmem_write,
    input  logic [DW-1:0] pmem_read_data,
    input  logic          pmem_read_ack,
    input  logic          pmem_write_ack,
    input  logic          pmem_nxm,
    output logic [1:0]    grant,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, LOCK0} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;   // 0: m0 served last, 1: m1 served last
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic m0_req, m1_req;
    logic own0, own1, drv;
    logic sel_rd, sel_wr;
    logic ack, to_fire, go;
    logic rack, wack, nxm;

    always_comb begin
        m0_req = m0_read | m0_write;
        m1_req = m1_read | m1_write;
        own0   = (state_q == BUSY0) || (state_q == LOCK0);
        own1   = (state_q == BUSY1);
        // LOCK0 only drives the bus while the pager actually has an op up.
        drv    = (state_q == BUSY0) || (state_q == BUSY1) ||
                 ((state_q == LOCK0) && m0_req);

        // Read has priority when a master raises both.
        sel_rd = own1 ? m1_read : m0_read;
        sel_wr = own1 ? (m1_write & ~m1_read) : (m0_write & ~m0_read);

        ack     = drv & (pmem_read_ack | pmem_write_ack);
        // A real ack in the timeout cycle wins over the forced completion.
        to_fire = drv & ~ack & (cnt_q == TO_W'(TIMEOUT));
        go      = ~reset & drv & ~to_fire;

        pmem_read       = go & sel_rd;
        pmem_write      = go & sel_wr;
        pmem_addr       = own1 ? m1_addr : m0_addr;
        pmem_write_data = own1 ? m1_write_data : m0_write_data;

        rack = ~reset & drv & (pmem_read_ack  | (to_fire & sel_rd));
        wack = ~reset & drv & (pmem_write_ack | (to_fire & sel_wr));
        nxm  = ~reset & drv & (pmem_nxm | to_fire);

        m0_read_ack  = own0 & rack;
        m0_write_ack = own0 & wack;
        m0_nxm       = own0 & nxm;
        m1_read_ack  = own1 & rack;
        m1_write_ack = own1 & wack;
        m1_nxm       = own1 & nxm;
        m0_read_data = pmem_read_data;
        m1_read_data = pmem_read_data;

        grant   = reset ? 2'b00 : {own0, own1};
        timeout = ~reset & to_fire;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || last_q))
                    state_d = BUSY0;
                else if (m1_req)
                    state_d = BUSY1;
            end
            default: begin
                if (drv) begin
                    if (ack || to_fire) begin
                        last_d  = own1;
                        cnt_d   = '0;
                        // Forced completion always releases the lock.
                        state_d = (ack && own0 && m0_lock) ? LOCK0 : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if ((state_q == LOCK0) && !m0_lock) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pmem_arb.sv
module tb_pmem_arb;
    localparam int AW = 22, DW = 36, TO_W = 10, TIMEOUT = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_addr, m1_addr, pmem_addr;
    logic [DW-1:0] m0_write_data, m1_write_data, pmem_write_data;
    logic [DW-1:0] m0_read_data, m1_read_data, pmem_read_data;
    logic          m0_read, m0_write, m0_lock, m1_read, m1_write;
    logic          m0_read_ack, m0_write_ack, m0_nxm;
    logic          m1_read_ack, m1_write_ack, m1_nxm;
    logic          pmem_read, pmem_write, pmem_read_ack, pmem_write_ack, pmem_nxm;
    logic [1:0]    grant;
    logic          timeout;

    int checks = 0;
    int failures = 0;

    pmem_arb #(.AW(AW), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_write_data(m0_write_data), .m0_read(m0_read),
        .m0_write(m0_write), .m0_lock(m0_lock), .m0_read_data(m0_read_data),
        .m0_read_ack(m0_read_ack), .m0_write_ack(m0_write_ack), .m0_nxm(m0_nxm),
        .m1_addr(m1_addr), .m1_write_data(m1_write_data), .m1_read(m1_read),
        .m1_write(m1_write), .m1_read_data(m1_read_data),
        .m1_read_ack(m1_read_ack), .m1_write_ack(m1_write_ack), .m1_nxm(m1_nxm),
        .pmem_addr(pmem_addr), .pmem_write_data(pmem_write_data),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_read_data(pmem_read_data), .pmem_read_ack(pmem_read_ack),
        .pmem_write_ack(pmem_write_ack), .pmem_nxm(pmem_nxm),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_write_data = '0; m1_write_data = '0;
        m0_read = 0; m0_write = 0; m0_lock = 0; m1_read = 0; m1_write = 0;
        pmem_read_data = '0; pmem_read_ack = 0; pmem_write_ack = 0; pmem_nxm = 0;

        // Reset: outputs forced low even with a request present.
        nxt(); nxt();
        m0_read = 1;
        settle();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_pmem_read", 64'(pmem_read), 64'(0));
        m0_read = 0;
        nxt();
        reset = 0;
        settle();
        chk("idle_grant", 64'(grant), 64'(0));

        // 1. m0 read at 0o1234, memory acks on the 3rd busy cycle.
        nxt();
        m0_addr = 22'o1234; m0_read = 1;
        settle();
        chk("t1_idle_no_req", 64'(pmem_read), 64'(0));
        nxt();
        settle();
        chk("t1_grant", 64'(grant), 64'(2'b10));
        chk("t1_pmem_read", 64'(pmem_read), 64'(1));
        chk("t1_pmem_addr", 64'(pmem_addr), 64'(22'o1234));
        nxt(); nxt();
        pmem_read_ack = 1; pmem_read_data = 36'h123456789;
        settle();
        chk("t1_m0_rack", 64'(m0_read_ack), 64'(1));
        chk("t1_m0_rdata", 64'(m0_read_data), 64'(36'h123456789));
        chk("t1_m1_rack", 64'(m1_read_ack), 64'(0));
        chk("t1_m0_nxm", 64'(m0_nxm), 64'(0));
        nxt();
        pmem_read_ack = 0; m0_read = 0;
        settle();
        chk("t1_back_idle", 64'(grant), 64'(0));

        // 2. Both request continuously: m0 was served last so m1 goes first,
        //    then strict alternation.
        m0_addr = 22'o100; m1_addr = 22'o200;
        m0_read = 1; m1_read = 1;
        for (int k = 0; k < 4; k++) begin
            nxt();
            settle();
            chk("t2_grant", 64'(grant), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            chk("t2_addr", 64'(pmem_addr), (k % 2 == 0) ? 64'(22'o200) : 64'(22'o100));
            nxt();
            pmem_read_ack = 1;
            settle();
            chk("t2_m0_rack", 64'(m0_read_ack), (k % 2 == 0) ? 64'(0) : 64'(1));
            chk("t2_m1_rack", 64'(m1_read_ack), (k % 2 == 0) ? 64'(1) : 64'(0));
            nxt();
            pmem_read_ack = 0;
            settle();
            chk("t2_idle", 64'(grant), 64'(0));
        end
        m0_read = 0; m1_read = 0;

        // 3. Locked pager sequence with m1 waiting throughout.
        nxt();
        m0_addr = 22'o300; m0_read = 1; m0_lock = 1;
        nxt();
        m1_addr = 22'o400; m1_write = 1; m1_write_data = 36'hABC;
        settle();
        chk("t3_grant_m0", 64'(grant), 64'(2'b10));
        nxt();
        pmem_read_ack = 1;
        settle();
        chk("t3_rack", 64'(m0_read_ack), 64'(1));
        nxt();
        pmem_read_ack = 0; m0_read = 0; m0_write = 1; m0_write_data = 36'h555;
        settle();
        chk("t3_lock_grant", 64'(grant), 64'(2'b10));
        chk("t3_lock_pwrite", 64'(pmem_write), 64'(1));
        chk("t3_lock_wdata", 64'(pmem_write_data), 64'(36'h555));
        nxt();
        pmem_write_ack = 1;
        settle();
        chk("t3_m0_wack", 64'(m0_write_ack), 64'(1));
        chk("t3_m1_wack", 64'(m1_write_ack), 64'(0));
        nxt();
        pmem_write_ack = 0; m0_write = 0;
        settle();
        chk("t3_hold_grant", 64'(grant), 64'(2'b10));
        chk("t3_hold_nowrite", 64'(pmem_write), 64'(0));
        nxt(); nxt();
        settle();
        chk("t3_still_held", 64'(grant), 64'(2'b10));
        m0_lock = 0;
        settle();
        chk("t3_release_cycle", 64'(grant), 64'(2'b10));
        nxt();
        settle();
        chk("t3_idle", 64'(grant), 64'(0));
        nxt();
        settle();
        chk("t3_m1_grant", 64'(grant), 64'(2'b01));
        chk("t3_m1_pwrite", 64'(pmem_write), 64'(1));
        chk("t3_m1_addr", 64'(pmem_addr), 64'(22'o400));

        // 4. No ack for m1's write: forced completion when the counter hits 1000.
        for (int i = 0; i < TIMEOUT - 1; i++) nxt();
        settle();
        chk("t4_pre_timeout", 64'(timeout), 64'(0));
        chk("t4_pre_pwrite", 64'(pmem_write), 64'(1));
        nxt();
        settle();
        chk("t4_timeout", 64'(timeout), 64'(1));
        chk("t4_m1_wack", 64'(m1_write_ack), 64'(1));
        chk("t4_m1_nxm", 64'(m1_nxm), 64'(1));
        chk("t4_pwrite_drop", 64'(pmem_write), 64'(0));
        chk("t4_m0_nxm", 64'(m0_nxm), 64'(0));
        m1_write = 0;
        nxt();
        settle();
        chk("t4_after_timeout", 64'(timeout), 64'(0));
        chk("t4_after_pwrite", 64'(pmem_write), 64'(0));
        chk("t4_after_grant", 64'(grant), 64'(0));

        // 5. m0 read+write together (read wins), memory answers with nxm.
        m0_read = 1; m0_write = 1;
        nxt();
        settle();
        chk("t5_pread", 64'(pmem_read), 64'(1));
        chk("t5_pwrite_supp", 64'(pmem_write), 64'(0));
        pmem_read_ack = 1; pmem_nxm = 1;
        settle();
        chk("t5_m0_nxm", 64'(m0_nxm), 64'(1));
        chk("t5_m0_rack", 64'(m0_read_ack), 64'(1));
        chk("t5_m1_nxm", 64'(m1_nxm), 64'(0));
        chk("t5_no_timeout", 64'(timeout), 64'(0));
        nxt();
        pmem_read_ack = 0; pmem_nxm = 0; m0_read = 0; m0_write = 0;

        // 6. Reset in the middle of an m1 op; afterwards m0 wins a tie.
        m1_write = 1;
        nxt();
        settle();
        chk("t6_m1_grant", 64'(grant), 64'(2'b01));
        reset = 1; pmem_write_ack = 1;
        settle();
        chk("t6_rst_grant", 64'(grant), 64'(0));
        chk("t6_rst_pwrite", 64'(pmem_write), 64'(0));
        chk("t6_rst_wack", 64'(m1_write_ack), 64'(0));
        nxt();
        settle();
        chk("t6_rst_hold", 64'(grant), 64'(0));
        reset = 0; pmem_write_ack = 0; m0_read = 1;
        settle();
        chk("t6_idle", 64'(grant), 64'(0));
        nxt();
        settle();
        chk("t6_m0_first", 64'(grant), 64'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
